keyboard_event_queue: RTL

//  Buffered, parametrised successor of the single-register keyboard port. Captures each decoded
//  key event (set-1 code, ASCII code, break flag) from the PS/2 decode/translate chain into a

---
 rtl/keyboard_event_queue.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/keyboard_event_queue.sv
`default_nettype none
// ============================================================================
// Module      : keyboard_event_queue
// Description : DEPTH-entry FIFO of decoded key events (set-1 code, ASCII,
//               break flag) with a 4-word memory-mapped register window and
//               a level interrupt while unread events are queued.
// Revision    : 1.0 - initial release
// ============================================================================
module keyboard_event_queue #(
   parameter int          DEPTH     = 16,
   parameter logic [15:0] BASE_ADDR = 16'h0000,
   parameter logic        MAKE_ONLY = 1'b0
) (
   input  logic        global_clk,
   input  logic        reset,
   input  logic        key_valid,
   input  logic [15:0] key_set1,
   input  logic [15:0] key_ascii,
   input  logic        key_break,
   input  logic [15:0] keyboard_ram_addr,
   input  logic        keyboard_ram_rd,
   input  logic        keyboard_ram_we,
   input  logic [15:0] keyboard_ram_wdata,
   output logic [15:0] keyboard_ram_data,
   output logic        keyboard_interrupt
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] c_full_count = CNT_W'(DEPTH);

   // Entry layout: [32] break, [31:16] ascii, [15:0] set-1 code
   logic [32:0]      r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             r_overflow;
   logic             r_irq_en;
   logic             r_make_only;
   logic [15:0]      r_data;
   logic             r_irq;

   logic [15:0]      w_offset;
   logic             w_in_window;
   logic             w_sel_ascii;
   logic             w_sel_status;
   logic             w_sel_ctrl;
   logic             w_empty;
   logic             w_full;
   logic             w_flush;
   logic             w_pop;
   logic             w_push_req;
   logic             w_push;
   logic             w_ovf_set;
   logic             w_ovf_clr;
   logic [32:0]      w_head;
   logic             w_head_brk;
   logic [15:0]      w_count16;
   logic [CNT_W-1:0] w_count_nxt;
   logic [PTR_W-1:0] w_wr_ptr_nxt;
   logic [PTR_W-1:0] w_rd_ptr_nxt;
   logic             w_ovf_nxt;
   logic             w_irq_en_nxt;
   logic             w_make_only_nxt;
   logic [15:0]      w_rdata;
   logic             w_unused_wdata;

   // Address decode: the window is four words starting at BASE_ADDR
   assign w_offset     = keyboard_ram_addr - BASE_ADDR;
   assign w_in_window  = (w_offset[15:2] == 14'd0);
   assign w_sel_ascii  = w_in_window && (w_offset[1:0] == 2'd1);
   assign w_sel_status = w_in_window && (w_offset[1:0] == 2'd2);
   assign w_sel_ctrl   = w_in_window && (w_offset[1:0] == 2'd3);

   assign w_empty    = (r_count == '0);
   assign w_full     = (r_count == c_full_count);
   assign w_head     = r_mem[r_rd_ptr];
   assign w_head_brk = !w_empty && w_head[32];
   assign w_count16  = 16'(r_count);

   // Flush beats any same-cycle event; a pop frees the slot a full push needs
   assign w_flush    = keyboard_ram_we && w_sel_ctrl && keyboard_ram_wdata[15];
   assign w_pop      = keyboard_ram_rd && w_sel_ascii && !w_empty;
   assign w_push_req = key_valid && !(r_make_only && key_break) && !w_flush;
   assign w_push     = w_push_req && (!w_full || w_pop);
   assign w_ovf_set  = w_push_req && w_full && !w_pop;
   assign w_ovf_clr  = keyboard_ram_we && w_sel_status && keyboard_ram_wdata[2];

   assign w_unused_wdata = ^keyboard_ram_wdata[14:3];

   // Next-state of pointers, occupancy, sticky overflow and control bits
   always_comb begin
      w_wr_ptr_nxt    = r_wr_ptr;
      w_rd_ptr_nxt    = r_rd_ptr;
      w_count_nxt     = r_count;
      w_ovf_nxt       = r_overflow;
      w_irq_en_nxt    = r_irq_en;
      w_make_only_nxt = r_make_only;
      if (keyboard_ram_we && w_sel_ctrl) begin
         w_irq_en_nxt    = keyboard_ram_wdata[0];
         w_make_only_nxt = keyboard_ram_wdata[1];
      end
      if (w_flush) begin
         w_wr_ptr_nxt = '0;
         w_rd_ptr_nxt = '0;
         w_count_nxt  = '0;
         w_ovf_nxt    = 1'b0;
      end else begin
         if (w_push) w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
         if (w_pop)  w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
         w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
         // A new overflow outranks a same-cycle clear
         if (w_ovf_set)      w_ovf_nxt = 1'b1;
         else if (w_ovf_clr) w_ovf_nxt = 1'b0;
      end
   end

   // Register read mux, evaluated on pre-update state so a popping read returns the popped entry
   always_comb begin
      w_rdata = 16'h0000;
      if (w_in_window) begin
         case (w_offset[1:0])
            2'd0:    w_rdata = w_empty ? 16'h0000 : w_head[15:0];
            2'd1:    w_rdata = w_empty ? 16'h0000 : w_head[31:16];
            2'd2:    w_rdata = {w_count16[7:0], 4'h0, w_head_brk, r_overflow, w_full, !w_empty};
            default: w_rdata = {14'd0, r_make_only, r_irq_en};
         endcase
      end
   end

   // Control/status state, read data and interrupt registers
   always_ff @(posedge global_clk) begin
      if (reset) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_overflow  <= 1'b0;
         r_irq_en    <= 1'b0;
         r_make_only <= MAKE_ONLY;
         r_data      <= 16'h0000;
         r_irq       <= 1'b0;
      end else begin
         r_wr_ptr    <= w_wr_ptr_nxt;
         r_rd_ptr    <= w_rd_ptr_nxt;
         r_count     <= w_count_nxt;
         r_overflow  <= w_ovf_nxt;
         r_irq_en    <= w_irq_en_nxt;
         r_make_only <= w_make_only_nxt;
         r_data      <= w_rdata;
         r_irq       <= w_irq_en_nxt && (w_count_nxt != '0);
      end
   end

   // Event storage; contents need no reset because the pointers define validity
   always_ff @(posedge global_clk) begin
      if (!reset && w_push) begin
         r_mem[r_wr_ptr] <= {key_break, key_ascii, key_set1};
      end
   end

   assign keyboard_ram_data  = r_data;
   assign keyboard_interrupt = r_irq;

endmodule
`default_nettype wire
